histogram_engine: RTL and testbench
===================================

Name: histogram_engine

Overview:
- Parametrised per-frame intensity histogram engine for the pixel stream.
- Accumulates one frame, then sweeps the bins: copies each count into a result RAM and clears the accumulator in the same pass.
- The result RAM holds the last completed frame and is readable at any time.
- Improvements over the previous generation:
  - configurable pixel, bin and count widths;
  - hazard-free read-modify-write for repeated bins;
  - saturating counts;
  - power-up clear;
  - explicit busy/done status.

Parameters:
- PIXEL_W, 8: pixel width in bits.
- BIN_BITS, 8: log2 of the bin count (NBINS = 2^BIN_BITS). Bin index = in_pixel[PIXEL_W-1 -: BIN_BITS]. Requires BIN_BITS <= PIXEL_W.
- COUNT_W, 16: width of each bin counter and of rd_data.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous active-high reset.
- in_pixel, input, PIXEL_W: pixel value.
- in_valid, input, 1: in_pixel is valid this cycle.
- frame_start, input, 1: arms accumulation for the next frame.
- end_of_frame, input, 1: marks the last pixel of the frame. Honoured only together with in_valid.
- rd_addr, input, BIN_BITS: result RAM read address.
- rd_data, output, COUNT_W: count of bin rd_addr for the last completed frame.
- busy, output, 1: high while a clear or dump sweep runs.
- done, output, 1: one-cycle pulse when the result RAM is updated.
- saturated, output, 1: at least one bin of the last completed frame hit 2^COUNT_W-1.
- dropped, output, 1: sticky flag, set when in_valid arrives while busy. Cleared by frame_start.

Behaviour:
- **Reset (rst=1):**
  - done, saturated, dropped = 0; busy = 1.
  - FSM enters CLEAR.
  - The accumulator RAM is zeroed over NBINS cycles; then FSM goes to IDLE and busy = 0.
  - Result RAM contents after power-up are undefined until the first done pulse.
- **FSM states:** CLEAR, IDLE, ACCUM, DRAIN, DUMP.
  - IDLE -> ACCUM on frame_start.
  - ACCUM -> DRAIN on in_valid & end_of_frame; that pixel is counted.
  - DRAIN lasts exactly 2 cycles, until the RMW pipeline is empty, then -> DUMP.
  - DUMP -> IDLE after the last bin write; done pulses in the cycle of entering IDLE.
  - CLEAR -> IDLE after NBINS writes.
- **frame_start:** in ACCUM, a frame_start without an intervening end_of_frame is ignored. In DUMP it is latched, and the FSM goes directly to ACCUM instead of IDLE (done still pulses).
- **Accumulation (ACCUM only):**
  - Pixels count only when in_valid=1.
  - 2-stage read-modify-write; RAM read latency 1 cycle.
  - Counts must be exact for any bin sequence, including the same bin on every cycle and same-bin pixels 1 or 2 cycles apart. Forward in-flight write values to achieve this.
  - Increment saturates at 2^COUNT_W-1, no wrap. Reaching saturation sets an internal flag; that flag is transferred to saturated at done and then cleared.
  - Pixels arriving in IDLE are ignored and do not set dropped.
- **DUMP sweep:**
  - Address runs 0..NBINS-1, one bin per cycle.
  - Each bin's count is written to the result RAM and 0 is written back to the accumulator.
  - Duration is NBINS + 2 cycles, measured from DUMP entry to the done pulse.
  - busy = 1 throughout DRAIN and DUMP.
  - in_valid during DRAIN, DUMP or CLEAR sets dropped; the pixel is discarded.
- **Result read port:** rd_data is registered, 1-cycle latency from rd_addr. It is independent of the FSM.
  - During DUMP, a read of a bin already written returns the new count.
  - A read of a bin not yet written returns the previous frame's count.
  - A read of the bin being written in that same cycle returns the old value (read-first).
- **rst mid-operation:** aborts any state and restarts CLEAR. The result RAM is not cleared and keeps the last completed frame.
- **Simultaneous end_of_frame and frame_start in ACCUM:** end_of_frame wins; frame_start is latched for the following frame.

Test Plan:
- **Reset clear:** with defaults, assert rst 1 cycle -> busy=1 for 256 cycles then 0. A frame of zero pixels (frame_start, then a single pixel 0 with end_of_frame) -> rd_data for bin 0 = 1, all other bins = 0.
- **Back-to-back same bin:** 100 consecutive pixels of value 0x37, end_of_frame on the last -> done after 2+258 cycles; bin 0x37 = 100, all other bins = 0.
- **Mixed-hazard sequence:** the pattern 5,5,9,5,9,9,5 repeated 10 times -> bin 5 = 40, bin 9 = 30. Repeat the test with in_valid gaps of 0, 1 and 2 cycles.
- **Saturation:** set COUNT_W=4 and send 20 pixels of value 200 -> bin 200 = 15, saturated=1 after done. The next frame without overflow -> saturated=0.
- **Parametrisation:** set PIXEL_W=10, BIN_BITS=6 and send pixels 0, 15, 16, 1023 -> bin 0 = 2, bin 1 = 1, bin 63 = 1.
- **Busy/drop and ping-pong read:** send in_valid during DUMP -> dropped=1 and the counts of both frames are unaffected. Poll rd_addr=3 during DUMP -> the value changes from the old to the new count exactly once, one cycle after bin 3 is written.

Source files
------------

// File: rtl/histogram_engine.sv
// histogram_engine
//   Per-frame intensity histogram. Pixels of one frame are counted into an
//   accumulator RAM through a forwarded 2-stage read-modify-write. When the
//   frame ends, a sweep copies every bin into a result RAM and zeroes the
//   accumulator in the same pass. The result RAM always holds the last
//   completed frame and can be read at any time.
//
// Ports
//   clk          : clock
//   rst          : synchronous active-high reset (restarts the accumulator clear)
//   in_pixel     : pixel value, bin = top BIN_BITS bits
//   in_valid     : in_pixel valid this cycle
//   frame_start  : arms accumulation of the next frame
//   end_of_frame : last pixel of the frame (qualified by in_valid)
//   rd_addr      : result RAM read address
//   rd_data      : result count, 1-cycle registered read latency
//   busy         : clear, drain or dump sweep in progress
//   done         : 1-cycle pulse when the result RAM has been refreshed
//   saturated    : a bin of the last completed frame reached full scale
//   dropped      : sticky, a pixel arrived while busy (cleared by frame_start)
module histogram_engine #(
  parameter int PIXEL_W  = 8,
  parameter int BIN_BITS = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIXEL_W-1:0]  in_pixel,
  input  logic                in_valid,
  input  logic                frame_start,
  input  logic                end_of_frame,
  input  logic [BIN_BITS-1:0] rd_addr,
  output logic [COUNT_W-1:0]  rd_data,
  output logic                busy,
  output logic                done,
  output logic                saturated,
  output logic                dropped
);

  localparam int NBINS = 1 << BIN_BITS;
  localparam int CW    = BIN_BITS + 1;

  localparam logic [CW-1:0]      C_NBINS    = CW'(NBINS);
  localparam logic [CW-1:0]      C_CLR_LAST = CW'(NBINS - 1);
  localparam logic [CW-1:0]      C_DUMP_END = CW'(NBINS + 1);
  localparam logic [CW-1:0]      C_ONE      = CW'(1);
  localparam logic [COUNT_W-1:0] C_MAX      = '1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DUMP
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_saturated;
  logic                r_dropped;
  logic                r_sat_flag;
  logic                r_fs_pend;

  // RMW pipeline: s1 = read returned, s2 = write pending, s3 = just written
  logic                r_s1_v;
  logic [BIN_BITS-1:0] r_s1_bin;
  logic                r_s2_v;
  logic [BIN_BITS-1:0] r_s2_bin;
  logic [COUNT_W-1:0]  r_s2_val;
  logic                r_s3_v;
  logic [BIN_BITS-1:0] r_s3_bin;
  logic [COUNT_W-1:0]  r_s3_val;

  // Dump pipeline: d1 = accumulator read returned, d2 = result write
  logic                r_d1_v;
  logic [BIN_BITS-1:0] r_d1_addr;
  logic                r_d2_v;
  logic [BIN_BITS-1:0] r_d2_addr;
  logic [COUNT_W-1:0]  r_d2_val;

  logic [COUNT_W-1:0]  r_acc_mem [NBINS];
  logic [COUNT_W-1:0]  r_acc_q;
  logic [COUNT_W-1:0]  r_res_mem [NBINS];
  logic [COUNT_W-1:0]  r_rd_data;

  logic [BIN_BITS-1:0] w_pix_bin;
  logic                w_accept;
  logic                w_dump_issue;
  logic [BIN_BITS-1:0] w_dump_addr;
  logic [BIN_BITS-1:0] w_acc_ra;
  logic                w_acc_we;
  logic [BIN_BITS-1:0] w_acc_wa;
  logic [COUNT_W-1:0]  w_acc_wd;
  logic [COUNT_W-1:0]  w_base;
  logic [COUNT_W-1:0]  w_inc;
  logic                w_busy_state;
  logic                w_unused_pix;

  assign w_pix_bin    = in_pixel[PIXEL_W-1 -: BIN_BITS];
  assign w_unused_pix = ^in_pixel;
  assign w_accept     = (r_state == S_ACCUM) && in_valid;
  assign w_dump_issue = (r_state == S_DUMP) && (r_cnt < C_NBINS);
  assign w_dump_addr  = r_cnt[BIN_BITS-1:0];
  assign w_acc_ra     = (r_state == S_DUMP) ? w_dump_addr : w_pix_bin;
  assign w_busy_state = (r_state == S_CLEAR) || (r_state == S_DRAIN) ||
                        (r_state == S_DUMP);

  // The RAM read for s1 was issued before the two newest writes landed
  // (one still pending in s2, one committed on the same edge as the read),
  // so both are forwarded, newest first.
  always_comb begin
    if (r_s2_v && (r_s2_bin == r_s1_bin)) begin
      w_base = r_s2_val;
    end else if (r_s3_v && (r_s3_bin == r_s1_bin)) begin
      w_base = r_s3_val;
    end else begin
      w_base = r_acc_q;
    end
    w_inc = (w_base == C_MAX) ? C_MAX : (w_base + COUNT_W'(1));
  end

  always_comb begin
    w_acc_we = 1'b0;
    w_acc_wa = '0;
    w_acc_wd = '0;
    if (r_state == S_CLEAR) begin
      w_acc_we = 1'b1;
      w_acc_wa = r_cnt[BIN_BITS-1:0];
    end else if (w_dump_issue) begin
      // read-first: the old count is captured on the same edge it is zeroed
      w_acc_we = 1'b1;
      w_acc_wa = w_dump_addr;
    end else if (r_s2_v) begin
      w_acc_we = 1'b1;
      w_acc_wa = r_s2_bin;
      w_acc_wd = r_s2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_we) begin
      r_acc_mem[w_acc_wa] <= w_acc_wd;
    end
    r_acc_q <= r_acc_mem[w_acc_ra];
  end

  always_ff @(posedge clk) begin
    if (r_d2_v) begin
      r_res_mem[r_d2_addr] <= r_d2_val;
    end
    r_rd_data <= r_res_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_saturated <= 1'b0;
      r_dropped   <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_fs_pend   <= 1'b0;
      r_s1_v      <= 1'b0;
      r_s2_v      <= 1'b0;
      r_s3_v      <= 1'b0;
      r_d1_v      <= 1'b0;
      r_d2_v      <= 1'b0;
    end else begin
      r_done    <= 1'b0;

      r_s1_v    <= w_accept;
      r_s1_bin  <= w_pix_bin;
      r_s2_v    <= r_s1_v;
      r_s2_bin  <= r_s1_bin;
      r_s2_val  <= w_inc;
      r_s3_v    <= r_s2_v;
      r_s3_bin  <= r_s2_bin;
      r_s3_val  <= r_s2_val;
      if (r_s1_v && (w_inc == C_MAX)) begin
        r_sat_flag <= 1'b1;
      end

      r_d1_v    <= w_dump_issue;
      r_d1_addr <= w_dump_addr;
      r_d2_v    <= r_d1_v;
      r_d2_addr <= r_d1_addr;
      r_d2_val  <= r_acc_q;

      if (frame_start) begin
        r_dropped <= 1'b0;
      end
      if (in_valid && w_busy_state) begin
        r_dropped <= 1'b1;
      end

      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + C_ONE;
          if (r_cnt == C_CLR_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid && end_of_frame) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            if (frame_start) begin
              r_fs_pend <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (frame_start) begin
            r_fs_pend <= 1'b1;
          end
          r_cnt <= r_cnt + C_ONE;
          if (r_cnt == C_ONE) begin
            r_state <= S_DUMP;
            r_cnt   <= '0;
          end
        end
        S_DUMP: begin
          if (frame_start) begin
            r_fs_pend <= 1'b1;
          end
          r_cnt <= r_cnt + C_ONE;
          // two extra cycles let the last bin pass through d1/d2
          if (r_cnt == C_DUMP_END) begin
            r_done      <= 1'b1;
            r_saturated <= r_sat_flag;
            r_sat_flag  <= 1'b0;
            r_fs_pend   <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_state     <= (r_fs_pend || frame_start) ? S_ACCUM : S_IDLE;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign saturated = r_saturated;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_histogram_engine.sv
module tb_histogram_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_pixel;
  logic       in_valid;
  logic       frame_start;
  logic       end_of_frame;
  logic [7:0] rd_addr;

  logic [15:0] rd_data_a;
  logic [3:0]  rd_data_b;
  logic [15:0] rd_data_c;
  logic busy_a, done_a, sat_a, drop_a;
  logic busy_b, done_b, sat_b, drop_b;
  logic busy_c, done_c, sat_c, drop_c;

  always #5 clk = ~clk;

  // A: defaults, B: 4-bit counters, C: 10-bit pixels into 64 bins.
  // All three share the same stimulus.
  histogram_engine #(.PIXEL_W(8), .BIN_BITS(8), .COUNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_pixel(in_pixel[7:0]), .in_valid(in_valid),
    .frame_start(frame_start), .end_of_frame(end_of_frame), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .saturated(sat_a),
    .dropped(drop_a));

  histogram_engine #(.PIXEL_W(8), .BIN_BITS(8), .COUNT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_pixel(in_pixel[7:0]), .in_valid(in_valid),
    .frame_start(frame_start), .end_of_frame(end_of_frame), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .saturated(sat_b),
    .dropped(drop_b));

  histogram_engine #(.PIXEL_W(10), .BIN_BITS(6), .COUNT_W(16)) u_c (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .frame_start(frame_start), .end_of_frame(end_of_frame),
    .rd_addr(rd_addr[5:0]), .rd_data(rd_data_c), .busy(busy_c), .done(done_c),
    .saturated(sat_c), .dropped(drop_c));

  typedef struct {
    int unsigned dut;   // 0 = A, 1 = B, 2 = C
    int unsigned addr;
    int unsigned exp;
  } vec_t;

  vec_t        vecs[$];
  int unsigned exp_a[256];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned p, input bit eof, input bit fs = 1'b0);
    in_pixel     = 10'(p);
    in_valid     = 1'b1;
    end_of_frame = eof;
    frame_start  = fs;
    tick();
    in_valid     = 1'b0;
    end_of_frame = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done_a && n < 3000) begin
      tick();
      n++;
    end
    check({name, " done within bound"}, 32'(n < 3000), 1);
  endtask

  task automatic add(input int unsigned dut, input int unsigned addr, input int unsigned exp);
    vec_t v;
    v.dut  = dut;
    v.addr = addr;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic read_bin(input int unsigned a);
    rd_addr = 8'(a);
    tick();
  endtask

  // A is swept completely (unlisted bins must be 0); B/C entries are spot reads.
  task automatic run_vecs(input string tag);
    for (int unsigned b = 0; b < 256; b++) exp_a[b] = 0;
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].dut == 0) exp_a[vecs[i].addr] = vecs[i].exp;
    for (int unsigned b = 0; b < 256; b++) begin
      read_bin(b);
      check($sformatf("%s A bin %0d", tag, b), rd_data_a, exp_a[b]);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut != 0) begin
        read_bin(vecs[i].addr);
        check($sformatf("%s %s bin %0d", tag, (vecs[i].dut == 1) ? "B" : "C", vecs[i].addr),
              (vecs[i].dut == 1) ? 32'(rd_data_b) : 32'(rd_data_c), vecs[i].exp);
      end
    end
    vecs.delete();
  endtask

  int unsigned pat[7] = '{5, 5, 9, 5, 9, 9, 5};

  initial begin
    int n;
    int nc;
    int k;
    int changes;
    int chg_k;
    int unsigned prev;

    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; end_of_frame = 1'b0;
    in_pixel = '0; rd_addr = '0;
    tick();
    check("reset busy", busy_a, 1);
    check("reset done", done_a, 0);
    check("reset saturated", sat_a, 0);
    check("reset dropped", drop_a, 0);
    rst = 1'b0;

    n = 0; nc = -1;
    while (busy_a && n < 1000) begin
      tick();
      n++;
      if (nc < 0 && !busy_c) nc = n;
    end
    check("clear busy cycles A", n, 256);
    check("clear busy cycles C", nc, 64);

    // single pixel frame
    start_frame();
    send(0, 1'b1);
    wait_done("t1", n);
    add(0, 0, 1);
    run_vecs("t1");

    // back-to-back same bin
    start_frame();
    for (int i = 0; i < 100; i++) send(8'h37, i == 99);
    check("t2 busy in drain", busy_a, 1);
    wait_done("t2", n);
    check("t2 done latency", n, 260);
    tick();
    check("t2 done pulse width", done_a, 0);
    check("t2 busy after done", busy_a, 0);
    add(0, 8'h37, 100);
    add(1, 8'h37, 15);
    run_vecs("t2");

    // mixed hazards with 0, 1, 2 idle cycles between pixels
    for (int g = 0; g < 3; g++) begin
      start_frame();
      for (int r = 0; r < 10; r++)
        for (int j = 0; j < 7; j++) begin
          send(pat[j], (r == 9) && (j == 6));
          repeat (g) tick();
        end
      wait_done($sformatf("t3 gap %0d", g), n);
      add(0, 5, 40);
      add(0, 9, 30);
      run_vecs($sformatf("t3 gap %0d", g));
    end

    // saturation on B, then a frame without overflow
    start_frame();
    for (int i = 0; i < 20; i++) send(200, i == 19);
    wait_done("t4a", n);
    check("t4a saturated B", sat_b, 1);
    check("t4a saturated A", sat_a, 0);
    add(0, 200, 20);
    add(1, 200, 15);
    run_vecs("t4a");
    start_frame();
    for (int i = 0; i < 3; i++) send(7, i == 2);
    wait_done("t4b", n);
    check("t4b saturated B", sat_b, 0);
    add(0, 7, 3);
    add(1, 7, 3);
    add(1, 200, 0);
    run_vecs("t4b");

    // parametrised bin extraction on C
    start_frame();
    send(0, 1'b0); send(15, 1'b0); send(16, 1'b0); send(1023, 1'b1);
    wait_done("t5", n);
    add(0, 0, 1); add(0, 15, 1); add(0, 16, 1); add(0, 255, 1);
    add(2, 0, 2); add(2, 1, 1); add(2, 63, 1); add(2, 2, 0); add(2, 62, 0);
    run_vecs("t5");

    // ping-pong read of bin 3 during dump, with pixels dropped meanwhile
    start_frame();
    for (int i = 0; i < 5; i++) send(3, i == 4);
    wait_done("t6a", n);
    start_frame();
    send(3, 1'b0); send(3, 1'b0); send(4, 1'b1);
    rd_addr = 8'd3;
    in_pixel = 10'd3;
    tick();
    k = 1;
    prev = rd_data_a;
    check("t6 old value", prev, 5);
    changes = 0; chg_k = 0;
    while (!done_a && k < 2000) begin
      in_valid = (k >= 2) && (k < 12);
      tick();
      k++;
      if (rd_data_a != prev) begin
        changes++;
        chg_k = k;
        prev = rd_data_a;
      end
    end
    in_valid = 1'b0;
    check("t6 done latency", k, 260);
    check("t6 value changes", changes, 1);
    check("t6 change cycle", chg_k, 9);
    check("t6 new value", prev, 2);
    check("t6 dropped set", drop_a, 1);
    add(0, 3, 2);
    add(0, 4, 1);
    run_vecs("t6b");
    start_frame();
    check("t6 dropped cleared", drop_a, 0);
    send(3, 1'b1);
    wait_done("t6c", n);
    add(0, 3, 1);
    run_vecs("t6c");

    // end_of_frame together with frame_start: next frame starts without IDLE
    start_frame();
    send(1, 1'b0);
    send(1, 1'b1, 1'b1);
    wait_done("t7a", n);
    tick();
    check("t7 busy after done", busy_a, 0);
    read_bin(1);
    check("t7a bin 1", rd_data_a, 2);
    send(2, 1'b1);
    wait_done("t7b", n);
    add(0, 2, 1);
    run_vecs("t7b");

    // reset mid-frame: accumulator cleared, result RAM kept
    start_frame();
    send(9, 1'b0);
    send(9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy_a && n < 1000) begin
      tick();
      n++;
    end
    check("t8 clear busy cycles", n, 256);
    read_bin(2);
    check("t8 result kept", rd_data_a, 1);
    start_frame();
    send(10, 1'b1);
    wait_done("t8", n);
    add(0, 10, 1);
    run_vecs("t8");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
